// File: rtl/formula_cex_scanner_pkg.sv
// Shared types and LFSR tap masks for the formula counterexample scanner.
package formula_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  // Right-shifting Galois masks: polynomial term x^e maps to bit e-1.
  localparam logic [54:0] LFSR_TAPS_55 = 55'h40000000800000;  // x^55+x^24+1
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;            // x^16+x^14+x^13+x^11+1
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;               // x^8+x^6+x^5+x^4+1

  // Returns zero for unsupported widths; the top turns that into an elaboration error.
  function automatic logic [63:0] lfsr_taps(input int n);
    case (n)
      8:       return {56'd0, LFSR_TAPS_8};
      16:      return {48'd0, LFSR_TAPS_16};
      55:      return {9'd0, LFSR_TAPS_55};
      default: return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/formula_cex_scanner_if.sv
// Control/result bundle between the scanner and whoever drives it, plus the formula vector/result pair.
interface formula_cex_scanner_if #(
  parameter int N_IN  = 55,
  parameter int CNT_W = 32
);
  import formula_scan_pkg::*;

  // start is a one-cycle request pulse with no ready: it is taken only when the
  // scanner is idle or done (busy=0) and silently dropped while busy=1. The
  // scan parameters are sampled on the same edge as start.
  logic             start;
  logic             mode;
  logic             stop_on_fail;
  logic [N_IN-1:0]  seed;
  logic [CNT_W-1:0] max_vec;
  logic [N_IN-1:0]  vec_o;
  logic             res_i;
  logic             busy;
  logic             done;
  logic             fail;
  logic [N_IN-1:0]  cex;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] fail_count;
  scan_state_e      dbg_state;

  modport slave (
    input  start, mode, stop_on_fail, seed, max_vec, res_i,
    output vec_o, busy, done, fail, cex, vec_count, fail_count, dbg_state
  );

  modport master (
    output start, mode, stop_on_fail, seed, max_vec, res_i,
    input  vec_o, busy, done, fail, cex, vec_count, fail_count, dbg_state
  );

endinterface

// File: rtl/formula_cex_scanner_scan_vec_gen.sv
// Combinational next-vector step: binary increment or one Galois LFSR shift, plus all-ones detect.
module scan_vec_gen #(
  parameter int              N_IN = 55,
  parameter logic [N_IN-1:0] TAPS = '0
) (
  input  logic [N_IN-1:0] i_vec,
  input  logic            i_mode,
  output logic [N_IN-1:0] o_next,
  output logic            o_all_ones
);

  always_comb begin
    o_next = '0;
    if (i_mode) begin
      o_next = (i_vec >> 1) ^ (i_vec[0] ? TAPS : '0);
    end else begin
      o_next = i_vec + N_IN'(1);
    end
  end

  assign o_all_ones = &i_vec;

endmodule

// File: rtl/formula_cex_scanner.sv
// Drives input vectors into a combinational formula, one per cycle, and collects pass/fail statistics.
module formula_cex_scanner
  import formula_scan_pkg::*;
#(
  parameter int N_IN  = 55,
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  formula_cex_scanner_if.slave bus
);

  localparam logic [N_IN-1:0] TAPS = N_IN'(lfsr_taps(N_IN));

  if (lfsr_taps(N_IN) == 64'd0) begin : g_bad_width
    $error("formula_cex_scanner: N_IN must be 8, 16 or 55");
  end

  scan_state_e      r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
  logic             r_mode;
  logic             r_sof;
  logic [N_IN-1:0]  r_vec;
  logic [N_IN-1:0]  r_cex;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_vc;
  logic [CNT_W-1:0] r_fc;

  logic [N_IN-1:0]  w_next;
  logic             w_all_ones;
  logic [CNT_W-1:0] w_vc_inc;
  logic             w_term;

  scan_vec_gen #(.N_IN(N_IN), .TAPS(TAPS)) u_vec_gen (
    .i_vec      (r_vec),
    .i_mode     (r_mode),
    .o_next     (w_next),
    .o_all_ones (w_all_ones)
  );

  assign w_vc_inc = r_vc + CNT_W'(1);
  // The count compare uses the incremented value so a K-vector scan stops on the K-th edge.
  assign w_term   = (!bus.res_i && r_sof) || (w_vc_inc == r_max) || (!r_mode && w_all_ones);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
      r_mode  <= 1'b0;
      r_sof   <= 1'b0;
      r_vec   <= '0;
      r_cex   <= '0;
      r_max   <= '0;
      r_vc    <= '0;
      r_fc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_mode <= bus.mode;
            r_sof  <= bus.stop_on_fail;
            r_max  <= bus.max_vec;
            r_fail <= 1'b0;
            r_cex  <= '0;
            r_vc   <= '0;
            r_fc   <= '0;
            // An all-zero LFSR state would lock up, so it is nudged to 1.
            r_vec  <= (bus.mode && (bus.seed == '0)) ? N_IN'(1) : bus.seed;
            if (bus.max_vec == '0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          r_vc <= w_vc_inc;
          if (!bus.res_i) begin
            if (r_fc != '1) r_fc <= r_fc + CNT_W'(1);
            if (!r_fail) begin
              r_fail <= 1'b1;
              r_cex  <= r_vec;
            end
          end
          if (w_term) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_vec <= w_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec_o      = r_vec;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.fail       = r_fail;
  assign bus.cex        = r_cex;
  assign bus.vec_count  = r_vc;
  assign bus.fail_count = r_fc;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_formula_cex_scanner.sv
// Bench for formula_cex_scanner: 8-bit and 55-bit instances, a per-cycle scan model and directed scans.
module tb_formula_cex_scanner;
  import formula_scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  formula_cex_scanner_if #(.N_IN(8),  .CNT_W(32)) bus8 ();
  formula_cex_scanner_if #(.N_IN(55), .CNT_W(32)) bus55 ();

  formula_cex_scanner #(.N_IN(8),  .CNT_W(32)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  formula_cex_scanner #(.N_IN(55), .CNT_W(32)) u_dut55 (.clk(clk), .rst_n(rst_n), .bus(bus55));

  // Stub formulas: 0 = always holds, 1 = fails only at 0x5A, 2 = odd vectors hold.
  int stub_sel = 0;

  function automatic logic stub_res(input int s, input logic [63:0] v);
    case (s)
      1:       return (v != 64'h5A);
      2:       return v[0];
      default: return 1'b1;
    endcase
  endfunction

  assign bus8.res_i  = stub_res(stub_sel, {56'd0, bus8.vec_o});
  assign bus55.res_i = stub_res(stub_sel, {9'd0, bus55.vec_o});

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        fail;
    logic [63:0] vec;
    logic [63:0] cex;
    logic [31:0] vc;
    logic [31:0] fc;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cur_w = 8;
  int            busy_cycles = 0;
  bit            seen[logic [63:0]];
  logic [63:0]   first_vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t observe(input int w);
    exp_t o;
    if (w == 8) begin
      o.busy = bus8.busy;  o.done = bus8.done;  o.fail = bus8.fail;
      o.vec  = {56'd0, bus8.vec_o};  o.cex = {56'd0, bus8.cex};
      o.vc   = bus8.vec_count;  o.fc = bus8.fail_count;
    end else begin
      o.busy = bus55.busy; o.done = bus55.done; o.fail = bus55.fail;
      o.vec  = {9'd0, bus55.vec_o};  o.cex = {9'd0, bus55.cex};
      o.vc   = bus55.vec_count; o.fc = bus55.fail_count;
    end
    return o;
  endfunction

  function automatic scan_state_e observe_state(input int w);
    return (w == 8) ? bus8.dbg_state : bus55.dbg_state;
  endfunction

  // Single compare process: one expected entry per cycle while a scan is being tracked.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t        e;
      exp_t        a;
      scan_state_e es;
      e  = exp_t'(exp_q.pop_front());
      a  = observe(cur_w);
      es = e.busy ? ST_RUN : (e.done ? ST_DONE : ST_IDLE);
      check("busy",       {63'd0, a.busy}, {63'd0, e.busy});
      check("done",       {63'd0, a.done}, {63'd0, e.done});
      check("fail",       {63'd0, a.fail}, {63'd0, e.fail});
      check("vec_o",      a.vec, e.vec);
      check("cex",        a.cex, e.cex);
      check("vec_count",  {32'd0, a.vc}, {32'd0, e.vc});
      check("fail_count", {32'd0, a.fc}, {32'd0, e.fc});
      check("state",      {62'd0, observe_state(cur_w)}, {62'd0, es});
      if (a.busy) begin
        busy_cycles++;
        seen[a.vec] = 1'b1;
        if (first_vecs.size() < 3) first_vecs.push_back(a.vec);
      end
    end
  end

  // Model: walk the scan vector by vector, emitting the state visible after each edge.
  task automatic build_model(input int w, input bit mode, input bit sof,
                             input logic [63:0] seed, input int unsigned maxv);
    logic [63:0] mask;
    logic [63:0] taps;
    logic [63:0] v;
    logic [63:0] cx;
    int unsigned k;
    int unsigned fc;
    bit          fl;
    bit          r;
    bit          term;
    exp_t        e;
    mask = (64'd1 << w) - 64'd1;
    taps = lfsr_taps(w);
    v    = seed & mask;
    if (mode && v == 64'd0) v = 64'd1;
    k = 0; fc = 0; fl = 1'b0; cx = 64'd0;
    e.busy = (maxv != 0); e.done = (maxv == 0); e.fail = 1'b0;
    e.vec = v; e.cex = 64'd0; e.vc = 32'd0; e.fc = 32'd0;
    exp_q.push_back(EW'(e));
    term = (maxv == 0);
    while (!term) begin
      r = stub_res(stub_sel, v);
      k++;
      if (!r) begin
        fc++;
        if (!fl) begin fl = 1'b1; cx = v; end
      end
      term = (!r && sof) || (k == maxv) || (!mode && v == mask);
      if (!term) v = mode ? ((v >> 1) ^ ({64{v[0]}} & taps)) : ((v + 64'd1) & mask);
      e.busy = !term; e.done = term; e.fail = fl;
      e.vec = v; e.cex = cx; e.vc = k; e.fc = fc;
      exp_q.push_back(EW'(e));
    end
    exp_q.push_back(EW'(e));  // DONE must hold one more cycle
  endtask

  // ---------------- driver ----------------
  task automatic drive_start(input int w, input bit mode, input bit sof,
                             input logic [63:0] seed, input int unsigned maxv);
    if (w == 8) begin
      bus8.mode = mode; bus8.stop_on_fail = sof; bus8.seed = seed[7:0];
      bus8.max_vec = maxv; bus8.start = 1'b1;
    end else begin
      bus55.mode = mode; bus55.stop_on_fail = sof; bus55.seed = seed[54:0];
      bus55.max_vec = maxv; bus55.start = 1'b1;
    end
  endtask

  task automatic run_scan(input int w, input bit mode, input bit sof,
                          input logic [63:0] seed, input int unsigned maxv);
    int c;
    @(negedge clk);
    #1;
    cur_w = w;
    busy_cycles = 0;
    seen.delete();
    first_vecs.delete();
    drive_start(w, mode, sof, seed, maxv);
    build_model(w, mode, sof, seed, maxv);
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus55.start = 1'b0;
    c = 0;
    while (exp_q.size() > 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scan_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- directed scans ----------------
  initial begin
    bus8.start = 1'b0;  bus8.mode = 1'b0;  bus8.stop_on_fail = 1'b0;  bus8.seed = '0;  bus8.max_vec = '0;
    bus55.start = 1'b0; bus55.mode = 1'b0; bus55.stop_on_fail = 1'b0; bus55.seed = '0; bus55.max_vec = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec",   {56'd0, bus8.vec_o}, 64'd0);
    check("rst_busy",  {63'd0, bus8.busy}, 64'd0);
    check("rst_done",  {63'd0, bus8.done}, 64'd0);
    check("rst_count", {32'd0, bus55.vec_count}, 64'd0);
    check("rst_state", {62'd0, bus8.dbg_state}, {62'd0, ST_IDLE});
    rst_n = 1'b1;

    // Exhaustive 8-bit, single failing vector 0x5A, ends on all-ones.
    stub_sel = 1;
    run_scan(8, 1'b0, 1'b0, 64'd0, 300);
    check("t1_vec_count",  {32'd0, bus8.vec_count}, 64'd256);
    check("t1_fail_count", {32'd0, bus8.fail_count}, 64'd1);
    check("t1_cex",        {56'd0, bus8.cex}, 64'h5A);
    check("t1_vec_last",   {56'd0, bus8.vec_o}, 64'hFF);
    check("t1_busy_cyc",   64'(busy_cycles), 64'd256);

    // Same stub, stop at the first failure.
    run_scan(8, 1'b0, 1'b1, 64'd0, 300);
    check("t2_vec_count", {32'd0, bus8.vec_count}, 64'd91);
    check("t2_vec_o",     {56'd0, bus8.vec_o}, 64'h5A);
    check("t2_busy_cyc",  64'(busy_cycles), 64'd91);

    // 55-bit LFSR from a zero seed.
    stub_sel = 0;
    run_scan(55, 1'b1, 1'b0, 64'd0, 1000);
    check("t3_busy_cyc", 64'(busy_cycles), 64'd1000);
    check("t3_distinct", 64'(seen.num()), 64'd1000);
    check("t3_fail",     {63'd0, bus55.fail}, 64'd0);
    if (first_vecs.size() == 3) begin
      check("t3_first", first_vecs[0], 64'd1);
      check("t3_second", first_vecs[1], 64'h40000000800000);
      check("t3_third", first_vecs[2], 64'h20000000400000);
    end else begin
      check("t3_first_count", 64'(first_vecs.size()), 64'd3);
    end

    // max_vec = 0: straight to DONE.
    run_scan(8, 1'b0, 1'b0, 64'd3, 0);
    check("t4_busy_cyc",  64'(busy_cycles), 64'd0);
    check("t4_vec_count", {32'd0, bus8.vec_count}, 64'd0);
    check("t4_done",      {63'd0, bus8.done}, 64'd1);

    // Odd vectors pass: 0..9 -> five failures, first at 0.
    stub_sel = 2;
    run_scan(8, 1'b0, 1'b0, 64'd0, 10);
    check("t5_fail_count", {32'd0, bus8.fail_count}, 64'd5);
    check("t5_cex",        {56'd0, bus8.cex}, 64'd0);
    check("t5_fail",       {63'd0, bus8.fail}, 64'd1);
    run_scan(8, 1'b0, 1'b0, 64'd7, 0);
    check("t5_clr_fc",   {32'd0, bus8.fail_count}, 64'd0);
    check("t5_clr_fail", {63'd0, bus8.fail}, 64'd0);
    check("t5_clr_vo",   {56'd0, bus8.vec_o}, 64'd7);

    // Asynchronous reset in the middle of a scan.
    stub_sel = 0;
    @(negedge clk);
    #1;
    drive_start(8, 1'b0, 1'b0, 64'h10, 300);
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_mid_busy",  {63'd0, bus8.busy}, 64'd1);
    check("t6_mid_count", {32'd0, bus8.vec_count}, 64'd4);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_vec",   {56'd0, bus8.vec_o}, 64'd0);
    check("t6_rst_busy",  {63'd0, bus8.busy}, 64'd0);
    check("t6_rst_count", {32'd0, bus8.vec_count}, 64'd0);
    check("t6_rst_fc",    {32'd0, bus8.fail_count}, 64'd0);
    check("t6_rst_state", {62'd0, bus8.dbg_state}, {62'd0, ST_IDLE});
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
